diag_tile_encoder: RTL and testbench

DIAG_TILE_ENCODER -- requirements
Module: diag_tile_encoder

---
 rtl/diag_tile_encoder_pkg.sv | 39 +++
 rtl/diag_tile_encoder_stage_timer.sv | 31 +++
 rtl/diag_tile_encoder.sv | 209 ++++++++++++++++++++
 tb/tb_diag_tile_encoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/diag_tile_encoder_pkg.sv
// diag_tile_pkg: shared state encoding, superblock geometry and stage timing
// constants for diag_tile_encoder and its stage timer.
package diag_tile_pkg;

  typedef enum logic [2:0] {
    IDLE              = 3'd0,
    READ_INPUT        = 3'd1,
    PREDICTION        = 3'd2,
    FORWARD_TX        = 3'd3,
    ENTROPY_ENCODE    = 3'd4,
    EMIT_SB_HEADER    = 3'd5,
    CHECK_SB_COMPLETE = 3'd6,
    DONE              = 3'd7
  } state_t;

  localparam int unsigned SB_SIZE     = 64;
  localparam int unsigned BEAT_PIXELS = 16;

  localparam int unsigned PRED_CYCLES = 6;
  localparam int unsigned FTX_CYCLES  = 6;
  localparam int unsigned ENT_CYCLES  = 11;

  // Wide enough to hold the longest stage length minus one.
  localparam int unsigned STAGE_CNT_W = 4;

  // ceil(0xFFFF/64) = 1024 needs 11 bits.
  localparam int unsigned SB_IDX_MIN_W = 11;

  localparam int unsigned SB_SHIFT = $clog2(SB_SIZE);

  // Number of superblocks covering a dimension; the 17-bit add keeps
  // 0xFFFF from wrapping to zero.
  function automatic logic [SB_IDX_MIN_W-1:0] sb_count(input logic [15:0] dim);
    logic [16:0] w_sum;
    w_sum = {1'b0, dim} + 17'(SB_SIZE - 1);
    return SB_IDX_MIN_W'(w_sum >> SB_SHIFT);
  endfunction

endpackage

// File: rtl/diag_tile_encoder_stage_timer.sv
// diag_stage_timer: loadable down-counter shared by the timed pipeline
// stages. Loading N-1 on stage entry makes o_done rise in the N-th cycle;
// the counter then rests at zero, so it is already cleared on stage exit.
module diag_stage_timer
  import diag_tile_pkg::*;
#(
  parameter int unsigned CNT_W = STAGE_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // Load on stage entry, otherwise count down and park at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/diag_tile_encoder.sv
// diag_tile_encoder: walks a frame through input read, then per-superblock
// prediction / forward transform / entropy stages, emitting one header word
// {sb_row, sb_col} per 64x64 superblock.
// Optional tracing: define DIAG_TILE_ENC_TRACE_EN to print state transitions
// and read progress; cycle behaviour is identical either way.
module diag_tile_encoder
  import diag_tile_pkg::*;
#(
  parameter int unsigned MAX_WIDTH   = 64,
  parameter int unsigned MAX_HEIGHT  = 64,
  parameter int unsigned PIXEL_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] frame_width,
  input  logic [15:0] frame_height,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        tile_done
);

  // Index width follows the configured maximum but never drops below what a
  // full 0xFFFF frame needs, so oversized frames still count correctly.
  localparam int unsigned MAX_DIM = (MAX_WIDTH > MAX_HEIGHT) ? MAX_WIDTH : MAX_HEIGHT;
  localparam int unsigned SB_MAX  = (MAX_DIM + SB_SIZE - 1) / SB_SIZE;
  localparam int unsigned IDX_W   = ($clog2(SB_MAX + 1) > SB_IDX_MIN_W) ?
                                    $clog2(SB_MAX + 1) : SB_IDX_MIN_W;
  localparam int unsigned BEAT_BITS = BEAT_PIXELS * PIXEL_WIDTH;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [IDX_W-1:0]       r_sb_rows;
  logic [IDX_W-1:0]       r_sb_cols;
  logic [IDX_W-1:0]       r_sb_row;
  logic [IDX_W-1:0]       r_sb_col;
  logic [31:0]            r_total_pixels;
  logic [31:0]            r_read_offset;
  logic                   r_tile_done;

  logic                   w_accept;
  logic                   w_zero_frame;
  logic                   w_col_more;
  logic                   w_row_more;
  logic                   w_timer_load;
  logic [STAGE_CNT_W-1:0] w_timer_val;
  logic                   w_timer_done;

  assign w_zero_frame = (frame_width == '0) || (frame_height == '0);
  assign in_ready     = (r_state == READ_INPUT) && (r_read_offset < r_total_pixels);
  assign w_accept     = in_valid && in_ready;
  assign w_col_more   = (r_sb_col < r_sb_cols - 1'b1);
  assign w_row_more   = (r_sb_row < r_sb_rows - 1'b1);

  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == EMIT_SB_HEADER);
  assign out_data  = (r_state == EMIT_SB_HEADER) ? {r_sb_row[7:0], r_sb_col[7:0]} : '0;
  assign tile_done = r_tile_done;

  diag_stage_timer #(
    .CNT_W (STAGE_CNT_W)
  ) u_stage_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_timer_load),
    .i_load_val (w_timer_val),
    .o_done     (w_timer_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; also loads the shared stage timer on entry to each
  // timed stage.
  always_comb begin
    w_next_state = r_state;
    w_timer_load = 1'b0;
    w_timer_val  = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = w_zero_frame ? DONE : READ_INPUT;
        end
      end
      READ_INPUT: begin
        if (r_read_offset >= r_total_pixels) begin
          w_next_state = PREDICTION;
          w_timer_load = 1'b1;
          w_timer_val  = STAGE_CNT_W'(PRED_CYCLES - 1);
        end
      end
      PREDICTION: begin
        if (w_timer_done) begin
          w_next_state = FORWARD_TX;
          w_timer_load = 1'b1;
          w_timer_val  = STAGE_CNT_W'(FTX_CYCLES - 1);
        end
      end
      FORWARD_TX: begin
        if (w_timer_done) begin
          w_next_state = ENTROPY_ENCODE;
          w_timer_load = 1'b1;
          w_timer_val  = STAGE_CNT_W'(ENT_CYCLES - 1);
        end
      end
      ENTROPY_ENCODE: begin
        if (w_timer_done) begin
          w_next_state = EMIT_SB_HEADER;
        end
      end
      EMIT_SB_HEADER: begin
        if (out_ready) begin
          w_next_state = CHECK_SB_COMPLETE;
        end
      end
      CHECK_SB_COMPLETE: begin
        if (w_col_more || w_row_more) begin
          w_next_state = PREDICTION;
          w_timer_load = 1'b1;
          w_timer_val  = STAGE_CNT_W'(PRED_CYCLES - 1);
        end else begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Frame geometry capture and read-offset accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb_rows      <= '0;
      r_sb_cols      <= '0;
      r_total_pixels <= '0;
      r_read_offset  <= '0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_sb_rows      <= IDX_W'(sb_count(frame_height));
        r_sb_cols      <= IDX_W'(sb_count(frame_width));
        r_total_pixels <= {16'd0, frame_width} * {16'd0, frame_height};
        r_read_offset  <= '0;
      end
    end else if (w_accept) begin
      // A partial last beat still advances by a full beat.
      r_read_offset <= r_read_offset + 32'(BEAT_PIXELS);
    end
  end

  // Superblock row/column walk, row-major.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb_row <= '0;
      r_sb_col <= '0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_sb_row <= '0;
        r_sb_col <= '0;
      end
    end else if (r_state == CHECK_SB_COMPLETE) begin
      if (w_col_more) begin
        r_sb_col <= r_sb_col + 1'b1;
      end else if (w_row_more) begin
        r_sb_col <= '0;
        r_sb_row <= r_sb_row + 1'b1;
      end
    end
  end

  // One-cycle completion pulse in the IDLE cycle that follows DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tile_done <= 1'b0;
    end else begin
      r_tile_done <= (r_state == DONE);
    end
  end

`ifdef DIAG_TILE_ENC_TRACE_EN
  // Transition and read-progress trace.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_next_state != r_state) begin
        $display("%0t diag_tile_encoder: %s -> %s sb_row=%0d sb_col=%0d",
                 $time, r_state.name(), w_next_state.name(), r_sb_row, r_sb_col);
      end
      if (w_accept && (((r_read_offset + 32'(BEAT_PIXELS)) % 32'd256) == 32'd0)) begin
        $display("%0t diag_tile_encoder: read %0d of %0d pixels (%0d-bit beats)",
                 $time, r_read_offset + 32'(BEAT_PIXELS), r_total_pixels, BEAT_BITS);
      end
    end
  end
`endif

endmodule

// File: tb/tb_diag_tile_encoder.sv
// Self-checking bench for diag_tile_encoder: directed table vectors, hand
// sequences for reset/start corner cases, and randomized frames checked
// against a superblock-count / latency model.
module tb_diag_tile_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] frame_width = '0;
  logic [15:0] frame_height = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        busy;
  logic        tile_done;

  diag_tile_encoder #(
    .MAX_WIDTH   (64),
    .MAX_HEIGHT  (64),
    .PIXEL_WIDTH (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .frame_width  (frame_width),
    .frame_height (frame_height),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .tile_done    (tile_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Cycle index: value k means edge k has occurred.
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Driver modes (written by the main sequence only).
  int iv_mode   = 0;  // 0: always valid, 1: random, 2: never
  int or_mode   = 0;  // 0: always ready, 1: random, 2: stall first header
  int stall_cfg = 0;
  int stall_left = 0;

  always @(posedge clk) begin
    #2;
    case (iv_mode)
      0:       in_valid = 1'b1;
      1:       in_valid = 1'($urandom_range(0, 1));
      default: in_valid = 1'b0;
    endcase
    if (!busy) stall_left = stall_cfg;
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && stall_left > 0) begin
          out_ready  = 1'b0;
          stall_left = stall_left - 1;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  end

  // Monitor: cumulative counters, sampled mid-cycle.
  int          beats_tot = 0;
  int          last_acc  = 0;
  int          done_tot  = 0;
  int          done_edge = 0;
  int          stall_tot = 0;
  int          stab_err  = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;
  logic [15:0] hdrs[$];

  always @(negedge clk) begin
    if (in_valid && in_ready) begin
      beats_tot = beats_tot + 1;
      last_acc  = cyc + 1;
    end
    if (out_valid && out_ready) hdrs.push_back(out_data);
    if (out_valid && !out_ready) begin
      stall_tot = stall_tot + 1;
      if (prev_stall && out_data != prev_data) stab_err = stab_err + 1;
    end
    if (out_valid && prev_stall && out_ready && out_data != prev_data) stab_err = stab_err + 1;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (tile_done) begin
      done_tot  = done_tot + 1;
      done_edge = cyc;
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    total = total + 1;
    if (act != req) begin
      bad = bad + 1;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: superblock headers in row-major order.
  function automatic int n_sb(input int dim);
    return (dim + 63) / 64;
  endfunction

  function automatic int model_hdr(input int w, input int idx);
    int nc, r, c;
    nc = n_sb(w);
    r  = idx / nc;
    c  = idx % nc;
    return ((r % 256) * 256) + (c % 256);
  endfunction

  task automatic start_pulse(output int sedge);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    sedge = cyc;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    int n;
    n = 0;
    while (done_tot == d0 && n < budget) begin
      @(posedge clk);
      n = n + 1;
    end
    if (n >= budget) check({tag, " done_timeout"}, 1, 0);
    repeat (6) @(posedge clk);
    #2;
  endtask

  // Runs one tile and checks beats, headers, pulse count and timing.
  // exp_lat < 0 selects the latency-from-last-beat check instead.
  task automatic run_tile(input int w, input int h, input int ivm, input int orm,
                          input int stall, input int exp_beats, input int exp_hdrs,
                          input int exp_lat, input string tag);
    int b0, h0, d0, s0, e0, sedge, nh, nstall;
    iv_mode = ivm; or_mode = orm; stall_cfg = stall;
    frame_width = 16'(w); frame_height = 16'(h);
    b0 = beats_tot; h0 = hdrs.size(); d0 = done_tot; s0 = stall_tot; e0 = stab_err;
    start_pulse(sedge);
    wait_done(d0, 20000, tag);
    nh     = hdrs.size() - h0;
    nstall = stall_tot - s0;
    check({tag, " beats"}, beats_tot - b0, exp_beats);
    check({tag, " hdr_count"}, nh, exp_hdrs);
    for (int i = 0; i < exp_hdrs; i++) begin
      if (i < nh) check({tag, " hdr_word"}, hdrs[h0 + i], model_hdr(w, i));
    end
    check({tag, " done_pulses"}, done_tot - d0, 1);
    check({tag, " stall_stable"}, stab_err - e0, 0);
    if (exp_lat >= 0) begin
      check({tag, " latency"}, done_edge - sedge, exp_lat);
    end else if (exp_beats > 0) begin
      check({tag, " tail_latency"}, done_edge - last_acc, 2 + 25 * exp_hdrs + nstall);
    end
    if (orm == 2) check({tag, " stall_cycles"}, nstall, stall);
    iv_mode = 0; or_mode = 0; stall_cfg = 0;
  endtask

  typedef struct {
    int w; int h; int ivm; int orm; int stall;
    int exp_beats; int exp_hdrs; int exp_lat;
    string tag;
  } vec_t;

  vec_t vt[7];

  initial begin
    int sedge, d0, h0, b0, w, h;

    vt[0] = '{64,  64, 0, 0, 0, 256, 1, 283, "f64x64"};
    vt[1] = '{128, 64, 0, 0, 0, 512, 2, 564, "f128x64"};
    vt[2] = '{65,  1,  0, 0, 0, 5,   2, 57,  "f65x1"};
    vt[3] = '{64,  64, 0, 2, 5, 256, 1, 288, "f64x64_stall"};
    vt[4] = '{0,   64, 0, 0, 0, 0,   0, 1,   "w0"};
    vt[5] = '{64,  0,  0, 0, 0, 0,   0, 1,   "h0"};
    vt[6] = '{1,   1,  0, 0, 0, 1,   1, 28,  "f1x1"};

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst tile_done", tile_done, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      run_tile(vt[i].w, vt[i].h, vt[i].ivm, vt[i].orm, vt[i].stall,
               vt[i].exp_beats, vt[i].exp_hdrs, vt[i].exp_lat, vt[i].tag);
    end

    // Start re-asserted mid-tile with a different width is ignored.
    frame_width = 16'd64; frame_height = 16'd64;
    d0 = done_tot; h0 = hdrs.size(); b0 = beats_tot;
    start_pulse(sedge);
    repeat (50) @(posedge clk);
    #2;
    check("busy_mid", busy, 1);
    frame_width = 16'd128;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    frame_width = 16'd64;
    wait_done(d0, 5000, "restart_ignored");
    check("restart_ignored beats", beats_tot - b0, 256);
    check("restart_ignored hdrs", hdrs.size() - h0, 1);
    check("restart_ignored latency", done_edge - sedge, 283);
    check("restart_ignored pulses", done_tot - d0, 1);

    // Start held through DONE: ignored there, begins a new tile in the
    // IDLE cycle carrying tile_done.
    frame_width = 16'd0; frame_height = 16'd5;
    d0 = done_tot;
    @(posedge clk); #2 start = 1'b1;
    repeat (3) @(posedge clk);
    #2 start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("held_start pulses", done_tot - d0, 2);

    // Reset during ENTROPY_ENCODE aborts the tile.
    frame_width = 16'd64; frame_height = 16'd64;
    d0 = done_tot; h0 = hdrs.size();
    start_pulse(sedge);
    while (cyc < sedge + 272) @(posedge clk);
    #2;
    check("pre_rst busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #2;
    check("abort busy", busy, 0);
    check("abort in_ready", in_ready, 0);
    check("abort out_valid", out_valid, 0);
    check("abort out_data", out_data, 0);
    check("abort tile_done", tile_done, 0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    check("abort hdrs", hdrs.size() - h0, 0);
    check("abort pulses", done_tot - d0, 0);
    run_tile(64, 64, 0, 0, 0, 256, 1, 283, "post_abort");

    // Randomized frames and handshakes against the model.
    for (int k = 0; k < 8; k++) begin
      w = $urandom_range(1, 160);
      h = $urandom_range(1, 100);
      run_tile(w, h, 1, 1, 0, (w * h + 15) / 16, n_sb(w) * n_sb(h), -1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
